// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory arbiter: FSM states,
// grant codes and RISC-V load/store funct3 encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DONE_IF = 2'b01,
    DONE_DM = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_DM   = 2'b10
  } gnt_t;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared single-port memory bus between the arbiter (master) and the
// byte-addressed memory instance (slave); read data is combinational.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection for the memory arbiter: eligibility per
// requester from the FSM state, then DM-first or round-robin priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  state_t state,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   prio_if,
  output gnt_t   gnt
);

  logic if_elig;
  logic dm_elig;

  // A requester still holds req during its own done cycle; it must not be
  // granted again until that pulse has passed.
  assign if_elig = if_req && (state != DONE_IF);
  assign dm_elig = dm_req && (state != DONE_DM);

  always_comb begin
    gnt = GNT_NONE;
    if (if_elig && dm_elig) begin
      gnt = prio_if ? GNT_IF : GNT_DM;
    end else if (dm_elig) begin
      gnt = GNT_DM;
    end else if (if_elig) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed DM priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,

  output logic              if_stall,
  output logic              dm_stall,

  mem_arbiter_if.master     mem
);

  state_t state;
  state_t state_next;
  gnt_t   gnt_raw;
  gnt_t   gnt;
  logic   prio_if;

  mem_arb_pick u_pick (
    .state   (state),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .prio_if (prio_if),
    .gnt     (gnt_raw)
  );

  // Reset kills the grant outright so a store on the reset edge never commits.
  assign gnt = rst ? GNT_NONE : gnt_raw;

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_if <= 1'b0;
    end else if (gnt == GNT_DM) begin
      prio_if <= 1'b1;
    end else if (gnt == GNT_IF) begin
      prio_if <= 1'b0;
    end
  end
`else
  assign prio_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    unique case (gnt)
      GNT_IF:  state_next = DONE_IF;
      GNT_DM:  state_next = DONE_DM;
      default: state_next = IDLE;
    endcase
  end

  assign if_done  = (state == DONE_IF);
  assign dm_done  = (state == DONE_DM);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_comb begin
    mem.mem_read   = 1'b0;
    mem.mem_write  = 1'b0;
    mem.mem_funct3 = '0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    unique case (gnt)
      GNT_IF: begin
        mem.mem_read   = 1'b1;
        mem.mem_funct3 = FUNCT3_LW;
        mem.mem_addr   = if_addr;
      end
      GNT_DM: begin
        mem.mem_read   = ~dm_we;
        mem.mem_write  = dm_we;
        mem.mem_funct3 = dm_funct3;
        mem.mem_addr   = dm_addr;
        mem.mem_wdata  = dm_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (gnt == GNT_IF) begin
        if_rdata <= mem.mem_rdata;
      end
      if (gnt == GNT_DM) begin
        dm_rdata <= dm_we ? '0 : mem.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a little-endian byte memory model
// and per-requester expected-data queues popped on each done pulse.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [2:0]  dm_funct3;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_done, dm_done, if_stall, dm_stall;
  logic        preload;

  int errors = 0;
  int checks = 0;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .mem(bus)
  );

  // Byte memory: 256 bytes, address wraps.
  logic [7:0] mb [0:255];
  logic [7:0] ra0, ra1, ra2, ra3;
  logic [7:0] wa;

  always_comb begin
    ra0 = bus.mem_addr[7:0];
    ra1 = ra0 + 8'd1;
    ra2 = ra0 + 8'd2;
    ra3 = ra0 + 8'd3;
    case (bus.mem_funct3)
      FUNCT3_LB:  bus.mem_rdata = {{24{mb[ra0][7]}}, mb[ra0]};
      FUNCT3_LH:  bus.mem_rdata = {{16{mb[ra1][7]}}, mb[ra1], mb[ra0]};
      FUNCT3_LBU: bus.mem_rdata = {24'h0, mb[ra0]};
      FUNCT3_LHU: bus.mem_rdata = {16'h0, mb[ra1], mb[ra0]};
      default:    bus.mem_rdata = {mb[ra3], mb[ra2], mb[ra1], mb[ra0]};
    endcase
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mb[i] <= 8'h00;
      mb[8'h10] <= 8'h93; mb[8'h11] <= 8'h00; mb[8'h12] <= 8'hA0; mb[8'h13] <= 8'h00;
      mb[8'h14] <= 8'h78; mb[8'h15] <= 8'h56; mb[8'h16] <= 8'h34; mb[8'h17] <= 8'h12;
    end else if (bus.mem_write) begin
      wa = bus.mem_addr[7:0];
      mb[wa] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) mb[wa + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        mb[wa + 8'd2] <= bus.mem_wdata[23:16];
        mb[wa + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse consumes one expected result.
  always @(negedge clk) begin
    if (if_done === 1'b1) begin
      if (if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (dm_done === 1'b1) begin
      if (dm_q.size() == 0) chk("dm_done_unexpected", 32'd1, 32'd0);
      else chk("dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  task automatic if_xact(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    if_q.push_back(exp);
    #1;
    chk("if_gnt_read", {bus.mem_read, bus.mem_write}, 32'b10);
    chk("if_gnt_funct3", bus.mem_funct3, FUNCT3_LW);
    chk("if_gnt_addr", bus.mem_addr, addr);
    chk("if_stall_wait", if_stall, 1);
    for (int w = 0; w < 8 && if_done !== 1'b1; w++) @(negedge clk);
    chk("if_done_seen", if_done, 1);
    chk("if_no_regrant", bus.mem_read, 0);
    chk("if_stall_done", if_stall, 0);
    if_req = 1'b0;
  endtask

  task automatic dm_xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp);
    @(negedge clk);
    dm_req = 1'b1; dm_we = we; dm_funct3 = f3; dm_addr = addr; dm_wdata = wdata;
    dm_q.push_back(exp);
    #1;
    chk("dm_gnt_strobes", {bus.mem_read, bus.mem_write}, {30'd0, ~we, we});
    chk("dm_gnt_funct3", bus.mem_funct3, f3);
    chk("dm_gnt_addr", bus.mem_addr, addr);
    chk("dm_gnt_wdata", bus.mem_wdata, wdata);
    for (int w = 0; w < 8 && dm_done !== 1'b1; w++) @(negedge clk);
    chk("dm_done_seen", dm_done, 1);
    chk("dm_no_regrant", {bus.mem_read, bus.mem_write}, 0);
    dm_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } dm_vec_t;

  dm_vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, FUNCT3_SW,  32'h20, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, FUNCT3_LBU, 32'h20, 32'h0,        32'h000000EF};
    vecs[2]  = '{1'b0, FUNCT3_LB,  32'h23, 32'h0,        32'hFFFFFFDE};
    vecs[3]  = '{1'b0, FUNCT3_LH,  32'h22, 32'h0,        32'hFFFFDEAD};
    vecs[4]  = '{1'b0, FUNCT3_LHU, 32'h20, 32'h0,        32'h0000BEEF};
    vecs[5]  = '{1'b0, FUNCT3_LH,  32'h20, 32'h0,        32'hFFFFBEEF};
    vecs[6]  = '{1'b1, FUNCT3_SB,  32'h21, 32'h12345680, 32'h0};
    vecs[7]  = '{1'b0, FUNCT3_LW,  32'h20, 32'h0,        32'hDEAD80EF};
    vecs[8]  = '{1'b1, FUNCT3_SH,  32'h22, 32'hAAAA1234, 32'h0};
    vecs[9]  = '{1'b0, FUNCT3_LW,  32'h20, 32'h0,        32'h123480EF};
    vecs[10] = '{1'b0, FUNCT3_LB,  32'h20, 32'h0,        32'hFFFFFFEF};
    vecs[11] = '{1'b0, FUNCT3_LBU, 32'h21, 32'h0,        32'h00000080};

    // Reset held two cycles with both requesters active.
    rst = 1'b1; preload = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = FUNCT3_LW; dm_addr = 32'h14; dm_wdata = 32'h5555AAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      preload = 1'b0;
      chk("rst_strobes_done", {bus.mem_read, bus.mem_write, if_done, dm_done}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
    end
    rst = 1'b0;
    dm_q.push_back(32'h12345678);
    if_q.push_back(32'h00A00093);
    #1;
    chk("rel_first_gnt_dm", bus.mem_addr, 32'h14);
    chk("rel_first_read", bus.mem_read, 1);
    @(negedge clk);
    chk("rel_dm_done", dm_done, 1);
    dm_req = 1'b0;
    #1;
    chk("rel_then_if", bus.mem_addr, 32'h10);
    @(negedge clk);
    chk("rel_if_done", if_done, 1);
    if_req = 1'b0;

    // Lone fetches.
    if_xact(32'h10, 32'h00A00093);
    if_xact(32'h14, 32'h12345678);

    // Data access table.
    foreach (vecs[i]) dm_xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    if_xact(32'h20, 32'h123480EF);

    // Both request from IDLE right after a DM grant.
    dm_xact(1'b0, FUNCT3_LW, 32'h14, 32'h0, 32'h12345678);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = FUNCT3_LBU; dm_addr = 32'h20;
    if_q.push_back(32'h00A00093);
    dm_q.push_back(32'h000000EF);
    #1;
    chk("tie_first_gnt", bus.mem_addr, RR ? 32'h10 : 32'h20);
    @(negedge clk);
    chk("tie_if_done_1", if_done, RR);
    chk("tie_dm_done_1", dm_done, !RR);
    if (RR) if_req = 1'b0; else dm_req = 1'b0;
    @(negedge clk);
    chk("tie_if_done_2", if_done, !RR);
    chk("tie_dm_done_2", dm_done, RR);
    if_req = 1'b0; dm_req = 1'b0;

    // dm_rdata holds across an IF access.
    if_xact(32'h10, 32'h00A00093);
    chk("dm_rdata_hold", dm_rdata, 32'h000000EF);

    // Reset asserted in the store grant cycle.
    @(negedge clk);
    rst = 1'b1;
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = FUNCT3_SW; dm_addr = 32'h40; dm_wdata = 32'hCAFEF00D;
    #1;
    chk("rst_store_no_write", bus.mem_write, 0);
    @(negedge clk);
    chk("rst_store_no_done", dm_done, 0);
    chk("rst_store_mem", {mb[8'h43], mb[8'h42], mb[8'h41], mb[8'h40]}, 0);
    rst = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk("rst_store_no_done_late", dm_done, 0);

    // Sustained contention: grants alternate DM, IF, DM, IF...
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = FUNCT3_LW; dm_addr = 32'h14;
    for (int n = 0; n < 4; n++) begin
      dm_q.push_back(32'h12345678);
      if_q.push_back(32'h00A00093);
    end
    for (int k = 0; k < 9; k++) begin
      logic exp_dm, exp_if;
      if (k > 0) @(negedge clk);
      #1;
      exp_dm = (k % 2 == 1);
      exp_if = (k > 0) && (k % 2 == 0);
      chk("cont_dm_done", dm_done, exp_dm);
      chk("cont_if_done", if_done, exp_if);
      chk("cont_dm_stall", dm_stall, dm_req & ~exp_dm);
      chk("cont_if_stall", if_stall, if_req & ~exp_if);
      chk("cont_mem_addr", bus.mem_addr, (k == 8) ? 32'h0 : ((k % 2 == 0) ? 32'h14 : 32'h10));
      if (k == 7) dm_req = 1'b0;
      if (k == 8) if_req = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("dm_q_drained", dm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
